// File: rtl/ex_mem_flags.sv
// EX/MEM boundary: pipeline register, Z/V/N flags, branch decision.
// Ports: EX bundle + alu_* in; mem_* bundle, flag_*, br_taken, halted out.
module ex_mem_flags #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [DW-1:0] alu_dst,
  input  logic          alu_ov,
  input  logic          alu_zr,
  input  logic [2:0]    alu_func,
  input  logic          ex_flag_wr,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_reg_we,
  input  logic          ex_mem_re,
  input  logic          ex_mem_we,
  input  logic [DW-1:0] ex_store_data,
  input  logic          ex_hlt,
  input  logic [2:0]    br_cond,
  output logic          mem_valid,
  output logic [DW-1:0] mem_alu_out,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_we,
  output logic          mem_mem_re,
  output logic          mem_mem_we,
  output logic          mem_hlt,
  output logic [DW-1:0] mem_store_data,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          br_taken,
  output logic          halted
);

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] alu;
    logic [RW-1:0] rd;
    logic          rwe;
    logic          re;
    logic          we;
    logic          hlt;
    logic [DW-1:0] sd;
  } ex_mem_t;

  ex_mem_t q;
  ex_mem_t d;
  logic    z_q, v_q, n_q;
  logic    z_d, v_d, n_d;
  logic    halt_q;
  logic    cap;

  assign cap = ex_valid & ~stall & ~flush & ~halt_q;

  always_comb begin
    d     = '0;
    d.vld = 1'b1;
    d.alu = alu_dst;
    d.rd  = ex_rd;
    d.rwe = ex_reg_we;
    d.re  = ex_mem_re;
    d.we  = ex_mem_we;
    d.hlt = ex_hlt;
    d.sd  = ex_store_data;
  end

  // Per-opcode flag rules; LHB keeps all flags.
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    n_d = n_q;
    case (alu_func)
      3'b000, 3'b001: begin
        z_d = alu_zr;
        v_d = alu_ov;
        n_d = alu_dst[DW-1];
      end
      3'b010, 3'b011,
      3'b100, 3'b101,
      3'b110: z_d = alu_zr;
      default: ;
    endcase
  end

  // rst > flush > stall > capture/bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      z_q    <= 1'b0;
      v_q    <= 1'b0;
      n_q    <= 1'b0;
      halt_q <= 1'b0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      if (cap) begin
        q <= d;
        if (ex_flag_wr) begin
          z_q <= z_d;
          v_q <= v_d;
          n_q <= n_d;
        end
        if (ex_hlt) halt_q <= 1'b1;
      end else begin
        q <= '0;
      end
    end
  end

  always_comb begin
    br_taken = 1'b0;
    unique case (br_cond)
      3'b000: br_taken = ~z_q;
      3'b001: br_taken = z_q;
      3'b010: br_taken = ~z_q & ~n_q;
      3'b011: br_taken = n_q;
      3'b100: br_taken = z_q | ~n_q;
      3'b101: br_taken = n_q | z_q;
      3'b110: br_taken = v_q;
      3'b111: br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  assign mem_valid      = q.vld;
  assign mem_alu_out    = q.alu;
  assign mem_rd         = q.rd;
  assign mem_reg_we     = q.rwe;
  assign mem_mem_re     = q.re;
  assign mem_mem_we     = q.we;
  assign mem_hlt        = q.hlt;
  assign mem_store_data = q.sd;
  assign flag_z         = z_q;
  assign flag_v         = v_q;
  assign flag_n         = n_q;
  assign halted         = halt_q;

endmodule

// File: tb/tb_ex_mem_flags.sv
// Testbench for ex_mem_flags: directed vector table plus
// a flag/branch-condition sweep.
module tb_ex_mem_flags;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid;
  logic [15:0] alu_dst;
  logic        alu_ov, alu_zr;
  logic [2:0]  alu_func;
  logic        ex_flag_wr;
  logic [3:0]  ex_rd;
  logic        ex_reg_we, ex_mem_re, ex_mem_we;
  logic [15:0] ex_store_data;
  logic        ex_hlt;
  logic [2:0]  br_cond;
  logic        mem_valid;
  logic [15:0] mem_alu_out;
  logic [3:0]  mem_rd;
  logic        mem_reg_we, mem_mem_re, mem_mem_we, mem_hlt;
  logic [15:0] mem_store_data;
  logic        flag_z, flag_v, flag_n, br_taken, halted;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_mem_flags #(.DW(16), .RW(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .alu_dst(alu_dst),
    .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_func(alu_func),
    .ex_flag_wr(ex_flag_wr), .ex_rd(ex_rd),
    .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re),
    .ex_mem_we(ex_mem_we), .ex_store_data(ex_store_data),
    .ex_hlt(ex_hlt), .br_cond(br_cond),
    .mem_valid(mem_valid), .mem_alu_out(mem_alu_out),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
    .mem_mem_re(mem_mem_re), .mem_mem_we(mem_mem_we),
    .mem_hlt(mem_hlt), .mem_store_data(mem_store_data),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .br_taken(br_taken), .halted(halted)
  );

  typedef struct {
    string       nm;
    logic        rst, stall, flush, vld;
    logic [2:0]  fn;
    logic        fw;
    logic [15:0] dst;
    logic        zr, ov;
    logic [3:0]  rd;
    logic        rwe;
    logic [15:0] sd;
    logic        hlt;
    logic [2:0]  br;
    logic        e_vld;
    logic [15:0] e_out;
    logic [3:0]  e_rd;
    logic        e_rwe;
    logic [15:0] e_sd;
    logic        e_hlt;
    logic [2:0]  e_zvn;
    logic        e_halted;
    logic        e_br;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input string nm,
    input logic r, input logic st, input logic fl,
    input logic v, input logic [2:0] fn, input logic fw,
    input logic [15:0] dst, input logic zr, input logic ov,
    input logic [3:0] rd, input logic rwe,
    input logic [15:0] sd, input logic hlt,
    input logic [2:0] br);
    vec_t t;
    t = '{default: '0};
    t.nm = nm; t.rst = r; t.stall = st; t.flush = fl;
    t.vld = v; t.fn = fn; t.fw = fw; t.dst = dst;
    t.zr = zr; t.ov = ov; t.rd = rd; t.rwe = rwe;
    t.sd = sd; t.hlt = hlt; t.br = br;
    tbl.push_back(t);
  endtask

  task automatic exp(
    input logic ev, input logic [15:0] eo,
    input logic [3:0] erd, input logic erwe,
    input logic [15:0] esd, input logic eh,
    input logic [2:0] zvn, input logic ehd, input logic eb);
    int k;
    k = tbl.size() - 1;
    tbl[k].e_vld = ev; tbl[k].e_out = eo;
    tbl[k].e_rd = erd; tbl[k].e_rwe = erwe;
    tbl[k].e_sd = esd; tbl[k].e_hlt = eh;
    tbl[k].e_zvn = zvn; tbl[k].e_halted = ehd;
    tbl[k].e_br = eb;
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; stall = t.stall; flush = t.flush;
    ex_valid = t.vld; alu_func = t.fn; ex_flag_wr = t.fw;
    alu_dst = t.dst; alu_zr = t.zr; alu_ov = t.ov;
    ex_rd = t.rd; ex_reg_we = t.rwe;
    ex_mem_re = t.rd[0]; ex_mem_we = t.rd[1];
    ex_store_data = t.sd; ex_hlt = t.hlt; br_cond = t.br;
  endtask

  function automatic logic ref_br(input logic [2:0] c,
    input logic z, input logic v, input logic n);
    case (c)
      3'd0: return ~z;
      3'd1: return z;
      3'd2: return ~z & ~n;
      3'd3: return n;
      3'd4: return z | (~z & ~n);
      3'd5: return n | z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  logic [58:0] act, req;

  initial begin
    vec_t t0;
    t0 = '{default: '0};
    drive(t0);
    rst = 1'b1;

    add("rst0", 1,0,0,0, 0,0, 16'h0,0,0, 0,0,16'h0,0, 3'd0);
    exp(0,16'h0,0,0,16'h0,0, 3'b000,0, 1);
    add("rst1", 1,0,0,0, 0,0, 16'h0,0,0, 0,0,16'h0,0, 3'd1);
    exp(0,16'h0,0,0,16'h0,0, 3'b000,0, 0);
    add("add_n", 0,0,0,1, 0,1, 16'h8000,0,0, 3,1,16'h1234,0, 3'd3);
    exp(1,16'h8000,3,1,16'h1234,0, 3'b001,0, 1);
    add("sub_v", 0,0,0,1, 1,1, 16'h7FFF,0,1, 4,1,16'h0,0, 3'd6);
    exp(1,16'h7FFF,4,1,16'h0,0, 3'b010,0, 1);
    add("and_z", 0,0,0,1, 2,1, 16'h0,1,0, 5,1,16'h0,0, 3'd1);
    exp(1,16'h0,5,1,16'h0,0, 3'b110,0, 1);
    add("lhb", 0,0,0,1, 7,1, 16'hAB00,0,0, 6,1,16'h0,0, 3'd6);
    exp(1,16'hAB00,6,1,16'h0,0, 3'b110,0, 1);
    add("shift", 0,0,0,1, 4,1, 16'h8000,0,1, 7,1,16'h5A5A,0, 3'd0);
    exp(1,16'h8000,7,1,16'h5A5A,0, 3'b010,0, 1);
    add("stall0", 0,1,0,1, 0,1, 16'h0001,1,0, 8,1,16'h1111,0, 3'd2);
    exp(1,16'h8000,7,1,16'h5A5A,0, 3'b010,0, 1);
    add("stall_hlt", 0,1,0,1, 0,1, 16'h8002,1,1, 9,0,16'h2222,1, 3'd2);
    exp(1,16'h8000,7,1,16'h5A5A,0, 3'b010,0, 1);
    add("stall2", 0,1,0,1, 1,1, 16'h0003,1,0, 10,1,16'h3333,0, 3'd6);
    exp(1,16'h8000,7,1,16'h5A5A,0, 3'b010,0, 1);
    add("stflush", 0,1,1,1, 0,1, 16'h1111,1,0, 9,1,16'h2222,0, 3'd1);
    exp(0,16'h0,0,0,16'h0,0, 3'b010,0, 0);
    add("inval", 0,0,0,0, 0,1, 16'hFFFF,1,1, 10,1,16'h3333,0, 3'd6);
    exp(0,16'h0,0,0,16'h0,0, 3'b010,0, 1);
    add("flush", 0,0,1,1, 0,1, 16'h0,1,0, 11,1,16'h4444,0, 3'd1);
    exp(0,16'h0,0,0,16'h0,0, 3'b010,0, 0);
    add("nofw", 0,0,0,1, 0,0, 16'h0,1,0, 2,0,16'h0,0, 3'd5);
    exp(1,16'h0,2,0,16'h0,0, 3'b010,0, 0);
    add("hlt", 0,0,0,1, 0,0, 16'h0,0,0, 0,0,16'h0,1, 3'd7);
    exp(1,16'h0,0,0,16'h0,1, 3'b010,1, 1);
    add("post_h", 0,0,0,1, 0,1, 16'h0001,1,0, 9,1,16'h0,0, 3'd1);
    exp(0,16'h0,0,0,16'h0,0, 3'b010,1, 0);
    add("post_h2", 0,0,0,1, 0,1, 16'h0001,1,0, 9,1,16'h0,0, 3'd1);
    exp(0,16'h0,0,0,16'h0,0, 3'b010,1, 0);
    add("rst_h", 1,0,0,1, 0,1, 16'h0001,1,0, 9,1,16'h0,0, 3'd4);
    exp(0,16'h0,0,0,16'h0,0, 3'b000,0, 1);
    add("add2", 0,0,0,1, 0,1, 16'h8001,0,0, 1,1,16'h0,0, 3'd4);
    exp(1,16'h8001,1,1,16'h0,0, 3'b001,0, 0);
    add("stall_pre", 0,1,0,0, 0,0, 16'h0,0,0, 0,0,16'h0,0, 3'd3);
    exp(1,16'h8001,1,1,16'h0,0, 3'b001,0, 1);
    add("rst_stall", 1,1,0,1, 0,1, 16'h0,1,0, 5,1,16'h0,0, 3'd3);
    exp(0,16'h0,0,0,16'h0,0, 3'b000,0, 0);

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      act = {mem_valid, mem_alu_out, mem_rd, mem_reg_we,
             mem_mem_re, mem_mem_we, mem_hlt, mem_store_data,
             flag_z, flag_v, flag_n, halted};
      req = {tbl[i].e_vld, tbl[i].e_out, tbl[i].e_rd,
             tbl[i].e_rwe, tbl[i].e_rd[0], tbl[i].e_rd[1],
             tbl[i].e_hlt, tbl[i].e_sd, tbl[i].e_zvn,
             tbl[i].e_halted};
      tests++;
      if (act !== req) begin
        fails++;
        $display("FAIL %s state: got %h want %h",
                 tbl[i].nm, act, req);
      end
      tests++;
      if (br_taken !== tbl[i].e_br) begin
        fails++;
        $display("FAIL %s br_taken: got %b want %b",
                 tbl[i].nm, br_taken, tbl[i].e_br);
      end
    end

    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    ex_hlt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] zvn;
      zvn = 3'(i);
      ex_valid = 1'b1; alu_func = 3'd1; ex_flag_wr = 1'b1;
      alu_zr = zvn[2]; alu_ov = zvn[1];
      alu_dst = {zvn[0], 15'h0};
      @(posedge clk); #1;
      ex_valid = 1'b0;
      tests++;
      if ({flag_z, flag_v, flag_n} !== zvn) begin
        fails++;
        $display("FAIL sweep_flags%0d: got %b want %b",
                 i, {flag_z, flag_v, flag_n}, zvn);
      end
      for (int c = 0; c < 8; c++) begin
        br_cond = 3'(c);
        #1;
        tests++;
        if (br_taken !== ref_br(3'(c), zvn[2], zvn[1], zvn[0])) begin
          fails++;
          $display("FAIL sweep zvn=%b cond=%0d: got %b want %b",
                   zvn, c, br_taken,
                   ref_br(3'(c), zvn[2], zvn[1], zvn[0]));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
